// File: rtl/drv_bus_arbiter.sv
// Turnaround-gapped round-robin ownership arbiter for one shared multi-driven net.
// Define DRV_ARB_WATCHDOG_EN to compile in the continuous-ownership watchdog.
module drv_bus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IdxW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    drv_en,
  output logic [IdxW-1:0] owner,
  output logic            busy,
  output logic            turn,
  output logic            wd_err
);

  if (N < 2 || N > 16 || TURN_CYC < 1 || TURN_CYC > 7 || MAX_HOLD < 2 || MAX_HOLD > 255)
  begin : g_param_check
    $error("drv_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    drv_en_q, drv_en_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [2:0]      turn_cnt_q, turn_cnt_d;
  logic            wd_err_q, wd_err_d;
  logic [N-1:0]    elig;
  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  logic            start_grant;

`ifdef DRV_ARB_WATCHDOG_EN
  logic [7:0]   hold_q, hold_d;
  logic [N-1:0] mask_q, mask_d;

  assign elig = req & ~mask_q;
`else
  assign elig = req;
`endif

  // First eligible requester at or after rr, wrapping.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_q) + i) % N;
      if (!pick_vld && elig[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drv_en_d    = drv_en_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    turn_cnt_d  = turn_cnt_q;
    wd_err_d    = 1'b0;
    start_grant = 1'b0;
`ifdef DRV_ARB_WATCHDOG_EN
    hold_d = hold_q;
    mask_d = mask_q & req;
`endif

    unique case (state_q)
      StIdle: begin
        start_grant = pick_vld;
      end
      StGrant: begin
        if (!req[owner_q]) begin
          drv_en_d   = '0;
          turn_cnt_d = 3'(TURN_CYC - 1);
          state_d    = StTurn;
`ifdef DRV_ARB_WATCHDOG_EN
        end else if (hold_q >= 8'(MAX_HOLD - 1)) begin
          // Hold limit hit: revoke and keep this driver out until it lets go of req.
          drv_en_d        = '0;
          turn_cnt_d      = 3'(TURN_CYC - 1);
          state_d         = StTurn;
          wd_err_d        = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          hold_d = (hold_q == 8'hff) ? hold_q : hold_q + 8'd1;
`endif
        end
      end
      StTurn: begin
        if (turn_cnt_q == 3'd0) begin
          start_grant = pick_vld;
          if (!pick_vld) state_d = StIdle;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_grant) begin
      drv_en_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
      owner_d  = pick_idx;
      rr_d     = (pick_idx == IdxW'(N - 1)) ? '0 : pick_idx + 1'b1;
      state_d  = StGrant;
`ifdef DRV_ARB_WATCHDOG_EN
      hold_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      drv_en_q   <= '0;
      owner_q    <= '0;
      rr_q       <= '0;
      turn_cnt_q <= '0;
      wd_err_q   <= 1'b0;
`ifdef DRV_ARB_WATCHDOG_EN
      hold_q     <= '0;
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      drv_en_q   <= drv_en_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      turn_cnt_q <= turn_cnt_d;
      wd_err_q   <= wd_err_d;
`ifdef DRV_ARB_WATCHDOG_EN
      hold_q     <= hold_d;
      mask_q     <= mask_d;
`endif
    end
  end

  assign drv_en = drv_en_q;
  assign owner  = owner_q;
  assign busy   = |drv_en_q;
  assign turn   = (state_q == StTurn);
  assign wd_err = wd_err_q;

endmodule

// File: tb/tb_drv_bus_arbiter.sv
// Directed bench for drv_bus_arbiter (N=4, TURN_CYC=1, MAX_HOLD=16).
// Expectations follow DRV_ARB_WATCHDOG_EN when it is defined for the build.
module tb_drv_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] drv_en;
  logic [1:0] owner;
  logic       busy;
  logic       turn;
  logic       wd_err;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [3:0]  prev_en;

  drv_bus_arbiter #(
    .N        (4),
    .TURN_CYC (1),
    .MAX_HOLD (16)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .drv_en (drv_en),
    .owner  (owner),
    .busy   (busy),
    .turn   (turn),
    .wd_err (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants, sampled mid-cycle.
  initial prev_en = '0;
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(drv_en)), 32'd1);
    check("busy_eq_or", 32'(busy), 32'(|drv_en));
    check("turn_gap", 32'(prev_en == 4'b0 || drv_en == 4'b0 || prev_en == drv_en), 32'd1);
    prev_en = drv_en;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] e_en;
    logic       e_wd;
    int unsigned o;
    n_checks = 0;
    n_errors = 0;

    // Reset with all requests pending.
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    step();
    check("rst_drv_en", 32'(drv_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wd_err", 32'(wd_err), 32'h0);
    check("rst_turn", 32'(turn), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    rst_n = 1'b1;
    step();
    check("first_grant", 32'(drv_en), 32'h1);

    // Round robin: 0,1,2,3,0 with one turn cycle between owners.
    o = 0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        check("rr_hold_en", 32'(drv_en), 32'(4'b0001 << o));
        check("rr_owner", 32'(owner), o);
        if (c < 2) step();
      end
      req[o] = 1'b0;
      step();
      check("rr_turn_en", 32'(drv_en), 32'h0);
      check("rr_turn", 32'(turn), 32'h1);
      req = 4'b1111;
      step();
      o = (o + 1) % 4;
      check("rr_next", 32'(drv_en), 32'(4'b0001 << o));
    end

    // No preemption: owner 2 keeps the bus while req[1] pulses.
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    check("np_grant2", 32'(drv_en), 32'h4);
    req = 4'b0110;
    step();
    check("np_hold_a", 32'(drv_en), 32'h4);
    req = 4'b0100;
    step();
    check("np_hold_b", 32'(drv_en), 32'h4);
    req = 4'b0110;
    step();
    check("np_hold_c", 32'(drv_en), 32'h4);
    req = 4'b0010;
    step();
    check("np_turn", 32'(turn), 32'h1);
    check("np_turn_en", 32'(drv_en), 32'h0);
    step();
    check("np_grant1", 32'(drv_en), 32'h2);
    check("np_owner1", 32'(owner), 32'h1);

    // Reset mid-grant.
    req = 4'b0000;
    step();
    req = 4'b1000;
    step();
    check("mg_grant3", 32'(drv_en), 32'h8);
    rst_n = 1'b0;
    req   = 4'b1001;
    step();
    check("mg_rst_en", 32'(drv_en), 32'h0);
    check("mg_rst_turn", 32'(turn), 32'h0);
    rst_n = 1'b1;
    step();
    check("mg_grant0", 32'(drv_en), 32'h1);

    // Watchdog scenario: req[1] and req[3] held for 40 cycles.
    req = 4'b0000;
    step();
    step();
    check("wd_idle", 32'(drv_en), 32'h0);
    req = 4'b1010;
    step();
    for (int j = 0; j < 40; j++) begin
`ifdef DRV_ARB_WATCHDOG_EN
      if (j < 16)                 e_en = 4'b0010;
      else if (j == 16 || j == 33) e_en = 4'b0000;
      else if (j < 33)            e_en = 4'b1000;
      else                        e_en = 4'b0000;
      e_wd = (j == 16 || j == 33);
`else
      e_en = 4'b0010;
      e_wd = 1'b0;
`endif
      check("wd_drv_en", 32'(drv_en), 32'(e_en));
      check("wd_pulse", 32'(wd_err), 32'(e_wd));
      if (j < 39) step();
    end
`ifdef DRV_ARB_WATCHDOG_EN
    // Driver 1 regains eligibility only after dropping req.
    req = 4'b1000;
    step();
    check("wd_still_idle", 32'(drv_en), 32'h0);
    req = 4'b1010;
    step();
    check("wd_regrant1", 32'(drv_en), 32'h2);
`else
    req = 4'b1000;
    step();
    check("nowd_turn", 32'(turn), 32'h1);
    check("nowd_turn_en", 32'(drv_en), 32'h0);
`endif
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
